// File: rtl/rv32_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port data SRAM between the
// single-cycle core data port and an external debug/DMA master.
module rv32_dmem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] c_addr,
    input  logic          c_read,
    input  logic          c_write,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    output logic          e_gnt,
    output logic          e_rvalid,
    output logic [DW-1:0] e_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {StIdle, StCrd, StErd} state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;  // 0: core granted last, 1: external granted last
    logic   c_req;

    assign c_req = c_read | c_write;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        c_rdata  = '0;
        c_stall  = 1'b0;
        e_gnt    = 1'b0;
        e_rvalid = 1'b0;
        e_rdata  = '0;
        m_en     = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        // Outputs are held at zero for as long as reset is asserted.
        if (reset_n) begin
            case (state_q)
                StIdle: begin
                    if (c_req && (!e_req || last_q)) begin
                        m_en    = 1'b1;
                        m_we    = c_write;
                        m_addr  = c_addr;
                        m_wdata = c_write ? c_wdata : '0;
                        c_stall = ~c_write;
                        last_d  = 1'b0;
                        if (!c_write) state_d = StCrd;
                    end else if (e_req) begin
                        e_gnt   = 1'b1;
                        m_en    = 1'b1;
                        m_we    = e_we;
                        m_addr  = e_addr;
                        m_wdata = e_wdata;
                        c_stall = c_req;
                        last_d  = 1'b1;
                        if (!e_we) state_d = StErd;
                    end
                end
                StCrd: begin
                    c_rdata = m_rdata;
                    state_d = StIdle;
                end
                StErd: begin
                    e_rvalid = 1'b1;
                    e_rdata  = m_rdata;
                    c_stall  = c_req;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_rv32_dmem_arbiter.sv
// Scoreboard bench for rv32_dmem_arbiter: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares on every grant, read-return or e_rvalid cycle.
module tb_rv32_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic        c_read = 1'b0, c_write = 1'b0, c_stall;
    logic        e_req = 1'b0, e_we = 1'b0, e_gnt, e_rvalid;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = '0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        m_en;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        e_gnt;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic [31:0] c_rdata;
        logic        c_stall;
    } obs_t;

    typedef struct {
        obs_t  v;
        string name;
    } exp_t;

    exp_t exp_q[$];

    rv32_dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .c_addr  (c_addr),
        .c_read  (c_read),
        .c_write (c_write),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_stall (c_stall),
        .e_req   (e_req),
        .e_we    (e_we),
        .e_addr  (e_addr),
        .e_wdata (e_wdata),
        .e_gnt   (e_gnt),
        .e_rvalid(e_rvalid),
        .e_rdata (e_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model with one-cycle read latency.
    logic [31:0] mem [0:255];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr[7:0]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:0]];
        end
    end

    function automatic obs_t snap();
        return {m_en, m_we, m_addr, m_wdata, e_gnt, e_rvalid, e_rdata, c_rdata, c_stall};
    endfunction

    function automatic void push(input string name, input logic en, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic gnt, input logic rv, input logic [31:0] erd,
                                 input logic [31:0] crd, input logic stall);
        exp_t e;
        e.v    = {en, we, addr, wdata, gnt, rv, erd, crd, stall};
        e.name = name;
        exp_q.push_back(e);
    endfunction

    // Monitor: a core read return is the cycle after a core read grant.
    logic crd_pend = 1'b0;
    always @(negedge clk) begin
        logic ret;
        obs_t act;
        exp_t e;
        if (!reset_n) begin
            crd_pend = 1'b0;
        end else begin
            ret      = crd_pend;
            crd_pend = m_en && !m_we && !e_gnt;
            if (m_en || e_rvalid || ret) begin
                act = snap();
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output got=%h required=none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e.v) begin
                        failures++;
                        $display("FAIL %s got=%h required=%h", e.name, act, e.v);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        obs_t act;
        act = snap();
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL %s got=%h required=0", name, act);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                         input logic [31:0] cd, input logic er, input logic ew,
                         input logic [31:0] ea, input logic [31:0] ed);
        c_read = cr; c_write = cw; c_addr = ca; c_wdata = cd;
        e_req = er; e_we = ew; e_addr = ea; e_wdata = ed;
    endtask

    initial begin
        // Reset held with both masters requesting: everything must read zero.
        drive(0, 1, 32'h40, 32'hA5A5A5A5, 1, 1, 32'h44, 32'h5A5A5A5A);
        #3;
        check_zero("rst_init");
        tick();
        tick();
        check_zero("rst_init_held");
        reset_n = 1'b1;
        push("rst_first_core", 1, 1, 32'h40, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        tick();
        push("rst_then_ext", 1, 1, 32'h44, 32'h5A5A5A5A, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Core-only write, then read back.
        drive(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        push("core_wr", 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        push("core_rd_grant", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
        tick();
        push("core_rd_data", 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // External read with the core idle.
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
        push("ext_rd_gnt", 1, 0, 32'h10, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        push("ext_rd_rvalid", 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        tick();

        // Conflicting writes for four cycles: core, ext, core, ext.
        drive(0, 1, 32'h20, 32'h11111111, 1, 1, 32'h24, 32'h22222222);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                push($sformatf("conf_core%0d", i), 1, 1, 32'h20, 32'h11111111, 0, 0, 0, 0, 0);
            else
                push($sformatf("conf_ext%0d", i), 1, 1, 32'h24, 32'h22222222, 1, 0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Back-to-back core reads while an external read is pending.
        drive(1, 0, 32'h20, 0, 1, 0, 32'h24, 0);
        push("starve_crd0", 1, 0, 32'h20, 0, 0, 0, 0, 0, 1);
        tick();
        push("starve_crd0_data", 0, 0, 0, 0, 0, 0, 0, 32'h11111111, 0);
        tick();
        push("starve_ext_gnt", 1, 0, 32'h24, 0, 1, 0, 0, 0, 1);
        tick();
        e_req = 1'b0;
        push("starve_ext_rvalid", 0, 0, 0, 0, 0, 1, 32'h22222222, 0, 1);
        tick();
        push("starve_crd1", 1, 0, 32'h20, 0, 0, 0, 0, 0, 1);
        tick();
        push("starve_crd1_data", 0, 0, 0, 0, 0, 0, 0, 32'h11111111, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Read and write together: only the write, no return cycle.
        drive(1, 1, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0);
        push("rw_both", 1, 1, 32'h30, 32'hCAFEF00D, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0, 32'h30, 0);
        push("rw_then_ext_gnt", 1, 0, 32'h30, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        push("rw_then_ext_rvalid", 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
        tick();

        // Reset during a core read return, with both masters requesting.
        drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
        push("rst_crd_grant", 1, 0, 32'h30, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 1, 32'h50, 32'h77777777, 1, 1, 32'h54, 32'h88888888);
        reset_n = 1'b0;
        #1;
        check_zero("rst_crd");
        tick();
        check_zero("rst_crd_held");
        reset_n = 1'b1;
        push("rst2_first_core", 1, 1, 32'h50, 32'h77777777, 0, 0, 0, 0, 0);
        tick();
        push("rst2_then_ext", 1, 1, 32'h54, 32'h88888888, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d_pending required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_dmem_arbiter.md
# rv32_dmem_arbiter

Two-master arbiter placed between the single-cycle core's data port and one single-port synchronous data SRAM. The second master is an external debug/DMA port. Round-robin arbitration, a read-return state machine, and a `c_stall` output handle sharing and the SRAM's 1-cycle read latency. Integration gates the core's PC/regfile update with `c_stall`.

## Interface
- `AW`, default 32: address width, all ports.
- `DW`, default 32: data width, all ports.
- `clk` in 1: clock, all state rising-edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `c_addr` in AW: core data address (ALU result).
- `c_read` in 1: core load request (MemRead).
- `c_write` in 1: core store request (MemWrite).
- `c_wdata` in DW: core store data.
- `c_rdata` out DW: core load data.
- `c_stall` out 1: core must not commit this cycle.
- `e_req` in 1: external request; held until `e_gnt`.
- `e_we` in 1: external write (1) / read (0).
- `e_addr` in AW: external address.
- `e_wdata` in DW: external write data.
- `e_gnt` out 1: one-cycle pulse, request accepted.
- `e_rvalid` out 1: one-cycle pulse, `e_rdata` valid.
- `e_rdata` out DW: external read data.
- `m_en` out 1: SRAM access strobe.
- `m_we` out 1: SRAM write enable.
- `m_addr` out AW: SRAM address.
- `m_wdata` out DW: SRAM write data.
- `m_rdata` in DW: SRAM read data, valid the cycle after a read strobe.

## Operation
- States:
  - `IDLE`: arbitration.
  - `CRD`: core read-return cycle.
  - `ERD`: external read-return cycle.
- Core request = `c_read | c_write`. If both are high, it is a write and the read is ignored.
- Register `last` (0 = core, 1 = ext) records the most recent grant.
- In `IDLE`:
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master not equal to `last`.
  - Grant updates `last`.
  - Exactly one grant per cycle; `m_en`=1 only on a grant cycle.
- Core write granted:
  - `m_en=1`, `m_we=1`, `m_addr=c_addr`, `m_wdata=c_wdata`.
  - `c_stall=0`; stay in `IDLE`.
- Core read granted:
  - `m_en=1`, `m_we=0`, `m_addr=c_addr`, `c_stall=1`.
  - Next state `CRD`.
- `CRD`:
  - `c_rdata=m_rdata`, `c_stall=0`, `m_en=0`.
  - Next state `IDLE`; no grant is issued in this cycle.
- External granted:
  - `e_gnt=1`, `m_en=1`, `m_we=e_we`, `m_addr=e_addr`, `m_wdata=e_wdata`.
  - Write: stay in `IDLE`. Read: next state `ERD`.
- `ERD`:
  - `e_rvalid=1`, `e_rdata=m_rdata`, `m_en=0`.
  - Next state `IDLE`.
- `c_stall`:
  - 1 in `IDLE` whenever the core requests and is not granted, or is granted a read.
  - 1 in `ERD` if the core requests.
  - 0 otherwise, including when the core has no request.
- `c_rdata` and `e_rdata` are 0 outside `CRD` and `ERD` respectively.
- Unused `m_addr` and `m_wdata` are 0 whenever `m_en=0`.

## Timing
- Reset (asynchronous):
  - State `IDLE`, `last`=1 (so the core wins the first conflict).
  - All outputs 0; `c_stall` is 0 while reset is asserted.
- Reset asserted mid-read (`CRD`/`ERD`): the return is abandoned and `e_rvalid` is not issued. The external master re-requests.
- Core write with no contention: 1 cycle, zero stall.
- Core read: 2 cycles; stall in cycle 1, data and commit in cycle 2.
- External write: `e_gnt` in the same cycle as the grant.
- External read: `e_rvalid` exactly 1 cycle after `e_gnt`.
- Fairness: with continuous core reads, a pending `e_req` is granted within 3 cycles of assertion. Symmetrically, the core is never denied twice in a row.
- `e_req` deasserted before `e_gnt` is a protocol violation with no defined response.
- `c_read`/`c_write` dropping during `CRD` is harmless: the state returns to `IDLE` regardless.
- Address/data are not registered; the SRAM samples `m_*` at the grant-cycle edge.

## Test plan
- **Reset:** assert `reset_n`=0 during `CRD` → all outputs 0 immediately; after release, a simultaneous core/ext request grants the core first.
- **Core-only write, then read:**
  - Write `c_addr`=0x10, `c_wdata`=0xDEADBEEF → `m_en`=`m_we`=1 the same cycle, `c_stall`=0.
  - Then read 0x10 → `c_stall`=1, then `c_rdata`=0xDEADBEEF with `c_stall`=0.
- **External read:** `e_req`=1, `e_we`=0, `e_addr`=0x10 with the core idle → `e_gnt` in cycle 0, `e_rvalid`=1 and `e_rdata`=0xDEADBEEF in cycle 1.
- **Conflict:** core write and ext write asserted together for 4 cycles → grants alternate core, ext, core, ext; `c_stall` pattern 0,1,0,1.
- **Starvation bound:** core issues back-to-back reads while `e_req` rises → `e_gnt` within 3 cycles; the core read in progress still returns correct data.
- **Both `c_read` and `c_write` high:** only the write is performed (`m_we`=1), `c_stall`=0, and no `CRD` state is entered.
